// File: rtl/shift_rows_engine_if.sv
// Handshake and data bundle for shift_rows_engine: an input state channel
// (in_valid/in_ready/dec/inp) and an output state channel
// (out_valid/out_ready/outp) plus the completion pulse.
interface shift_rows_engine_if #(
    parameter int NB = 4,
    parameter int BW = 8
);
    logic                       in_valid;
    logic                       in_ready;
    logic                       dec;
    logic [4*NB-1:0][BW-1:0]    inp;
    logic [4*NB-1:0][BW-1:0]    outp;
    logic                       out_valid;
    logic                       out_ready;
    logic                       done;

    // Producer/consumer side: presents states and accepts results.
    modport master (
        output in_valid, dec, inp, out_ready,
        input  in_ready, outp, out_valid, done
    );

    // Engine side.
    modport slave (
        input  in_valid, dec, inp, out_ready,
        output in_ready, outp, out_valid, done
    );
endinterface

// File: rtl/shift_rows_engine.sv
// AES-style (Inv)ShiftRows engine for NB = 4, 6 or 8 columns. A state is
// captured in IDLE, the output register is filled one row per cycle in ROW,
// and the result is held in OUT until the consumer takes it.
module shift_rows_engine #(
    parameter int NB = 4,
    parameter int BW = 8
) (
    input  logic              clk,
    input  logic              resetn,   // synchronous, active-high
    shift_rows_engine_if.slave bus
);

    // Column-major view of the state: [column][row][bit]. Bit layout is the
    // same as the flat [4*NB-1:0][BW-1:0] bus packing (byte k = col*4+row).
    typedef logic [NB-1:0][3:0][BW-1:0] grid_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROW  = 2'd1,
        OUT  = 2'd2
    } state_e;

    if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
        $error("shift_rows_engine: NB must be 4, 6 or 8");
    end

    // Row rotation amount; rows 2 and 3 rotate one further at NB=8.
    function automatic int row_shift(input int r);
        if (NB == 8 && r >= 2) begin
            return r + 1;
        end
        return r;
    endfunction

    state_e      state_q, state_d;
    logic [1:0]  rc_q, rc_d;
    grid_t       in_q, in_d;
    logic        dec_q, dec_d;
    grid_t       out_q, out_d;
    logic        done_q, done_d;
    logic        in_ready_c;

    // Every row of the captured state rotated for the captured direction.
    // Source columns are elaboration-time constants, so this is pure wiring
    // plus one 2:1 mux per byte.
    logic [3:0][NB-1:0][BW-1:0] rot_w;

    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int SRC_ENC = (c + row_shift(r)) % NB;
            localparam int SRC_DEC = (c - row_shift(r) + NB) % NB;
            assign rot_w[r][c] = dec_q ? in_q[SRC_DEC][r] : in_q[SRC_ENC][r];
        end
    end

    // Next-state, capture, row write-back and handshake decode.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        rc_d       = rc_q;
        in_d       = in_q;
        dec_d      = dec_q;
        out_d      = out_q;
        done_d     = 1'b0;
        in_ready_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    in_d    = bus.inp;
                    dec_d   = bus.dec;
                    rc_d    = 2'd0;
                    state_d = ROW;
                end
            end
            ROW: begin
                for (int c = 0; c < NB; c++) begin
                    out_d[c][rc_q] = rot_w[rc_q][c];
                end
                rc_d = rc_q + 2'd1;
                if (rc_q == 2'd3) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                in_ready_c = bus.out_ready;
                if (bus.out_ready) begin
                    done_d = 1'b1;
                    if (bus.in_valid) begin
                        in_d    = bus.inp;
                        dec_d   = bus.dec;
                        rc_d    = 2'd0;
                        state_d = ROW;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: registers are updated with <= so every flop samples the
        // values from before this edge, independent of statement order.
        if (resetn) begin
            state_q <= IDLE;
            rc_q    <= 2'd0;
            dec_q   <= 1'b0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rc_q    <= rc_d;
            dec_q   <= dec_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    // Captured input state.
    always_ff @(posedge clk) begin
        // NOTE: pure data capture with no reset; it is always written on
        // acceptance before anything reads it, so a reset would only add
        // fan-out to the reset net.
        in_q <= in_d;
    end

    assign bus.in_ready  = in_ready_c & ~resetn;
    assign bus.out_valid = (state_q == OUT);
    assign bus.outp      = out_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_shift_rows_engine.sv
// Self-checking bench for shift_rows_engine: one NB=4 and one NB=8 instance,
// driven through a shared stimulus set and steered by sel.
module tb_shift_rows_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              resetn;
    logic              sel;        // 0 = NB4 instance, 1 = NB8 instance
    logic              in_valid;
    logic              dec;
    logic              out_ready;
    logic [31:0][7:0]  inp;

    int checks   = 0;
    int failures = 0;

    shift_rows_engine_if #(.NB(4), .BW(8)) bus4 ();
    shift_rows_engine_if #(.NB(8), .BW(8)) bus8 ();

    assign bus4.in_valid  = in_valid & ~sel;
    assign bus4.dec       = dec;
    assign bus4.inp       = inp[15:0];
    assign bus4.out_ready = out_ready & ~sel;
    assign bus8.in_valid  = in_valid & sel;
    assign bus8.dec       = dec;
    assign bus8.inp       = inp;
    assign bus8.out_ready = out_ready & sel;

    shift_rows_engine #(.NB(4), .BW(8)) dut4 (.clk(clk), .resetn(resetn), .bus(bus4.slave));
    shift_rows_engine #(.NB(8), .BW(8)) dut8 (.clk(clk), .resetn(resetn), .bus(bus8.slave));

    logic             in_ready_m, out_valid_m, done_m;
    logic [31:0][7:0] outp_m;
    assign in_ready_m  = sel ? bus8.in_ready  : bus4.in_ready;
    assign out_valid_m = sel ? bus8.out_valid : bus4.out_valid;
    assign done_m      = sel ? bus8.done      : bus4.done;
    assign outp_m      = sel ? bus8.outp      : {128'b0, bus4.outp};

    // Reference: out[r][c] = in[r][(c +/- s_r) mod nb], byte k = col*4+row.
    function automatic logic [31:0][7:0] model(input int nb, input logic d,
                                               input logic [31:0][7:0] x);
        logic [31:0][7:0] y;
        int s, src;
        y = '0;
        for (int r = 0; r < 4; r++) begin
            s = (nb == 8 && r >= 2) ? r + 1 : r;
            for (int c = 0; c < nb; c++) begin
                src = d ? (c - s + nb) % nb : (c + s) % nb;
                y[c*4 + r] = x[src*4 + r];
            end
        end
        return y;
    endfunction

    function automatic logic [31:0][7:0] rand_state();
        logic [31:0][7:0] v;
        for (int k = 0; k < 32; k++) v[k] = 8'($urandom);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a state, accept it, scramble inputs while it is in flight and
    // wait (bounded) for out_valid; the result must be up 4 edges after the
    // accepting edge, i.e. visible for the 5th edge.
    task automatic start_xact(input logic [31:0][7:0] din, input logic d, input string tag);
        int lat;
        in_valid  = 1'b1;
        inp       = din;
        dec       = d;
        out_ready = 1'b0;
        #1;
        checks++;
        if (in_ready_m !== 1'b1) begin
            failures++;
            $display("FAIL %s accept: in_ready=%b expected 1", tag, in_ready_m);
        end
        tick();
        lat = 0;
        while (out_valid_m !== 1'b1 && lat < 20) begin
            in_valid = 1'b0;
            inp      = rand_state();
            dec      = 1'($urandom);
            lat++;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (lat != 4) begin
            failures++;
            $display("FAIL %s latency: edges=%0d expected 4", tag, lat);
        end
    endtask

    task automatic finish_xact(input string tag);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        tick();
        out_ready = 1'b0;
        checks++;
        if (done_m !== 1'b1 || out_valid_m !== 1'b0) begin
            failures++;
            $display("FAIL %s handshake: done=%b out_valid=%b expected 1/0", tag, done_m, out_valid_m);
        end
        tick();
        checks++;
        if (done_m !== 1'b0) begin
            failures++;
            $display("FAIL %s done_width: done=%b expected 0", tag, done_m);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b1; sel = 1'b0; in_valid = 1'b0; dec = 1'b0; out_ready = 1'b0; inp = '0;
        tick(); tick();
        checks++;
        if (in_ready_m !== 1'b0 || out_valid_m !== 1'b0 || done_m !== 1'b0 || outp_m !== '0) begin
            failures++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b done=%b outp=%h expected 0/0/0/0",
                     in_ready_m, out_valid_m, done_m, outp_m);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if (in_ready_m !== 1'b1) begin
            failures++;
            $display("FAIL reset_release: in_ready=%b expected 1", in_ready_m);
        end
    endtask

    task automatic test_vectors();
        logic [7:0] enc_ref [16] = '{8'h00, 8'h05, 8'h0A, 8'h0F, 8'h04, 8'h09, 8'h0E, 8'h03,
                                     8'h08, 8'h0D, 8'h02, 8'h07, 8'h0C, 8'h01, 8'h06, 8'h0B};
        logic [31:0][7:0] din, exp_v;
        sel = 1'b0;
        din = '0; exp_v = '0;
        for (int k = 0; k < 16; k++) begin
            din[k]   = 8'(k);
            exp_v[k] = enc_ref[k];
        end
        start_xact(din, 1'b0, "nb4_enc");
        checks++;
        if (outp_m !== exp_v || out_valid_m !== 1'b1) begin
            failures++;
            $display("FAIL nb4_enc: outp=%h out_valid=%b expected %h/1", outp_m, out_valid_m, exp_v);
        end
        finish_xact("nb4_enc");
        start_xact(exp_v, 1'b1, "nb4_dec");
        checks++;
        if (outp_m !== din) begin
            failures++;
            $display("FAIL nb4_dec: outp=%h expected %h", outp_m, din);
        end
        finish_xact("nb4_dec");
    endtask

    task automatic test_nb8_wrap();
        logic [31:0][7:0] din;
        sel = 1'b1;
        for (int k = 0; k < 32; k++) din[k] = 8'(k);
        start_xact(din, 1'b0, "nb8_enc");
        checks++;
        if (outp_m[3:0] !== {8'h13, 8'h0E, 8'h05, 8'h00}) begin
            failures++;
            $display("FAIL nb8_col0: got %h expected 130e0500", outp_m[3:0]);
        end
        checks++;
        if (outp_m[31:28] !== {8'h0F, 8'h0A, 8'h01, 8'h1C}) begin
            failures++;
            $display("FAIL nb8_col7: got %h expected 0f0a011c", outp_m[31:28]);
        end
        finish_xact("nb8_enc");
        sel = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0][7:0] din, exp_v;
        logic d;
        int nb;
        for (int i = 0; i < 24; i++) begin
            sel = (i >= 12);
            nb  = sel ? 8 : 4;
            din = rand_state();
            d   = 1'($urandom);
            exp_v = model(nb, d, din);
            start_xact(din, d, "random");
            checks++;
            if (outp_m !== exp_v) begin
                failures++;
                $display("FAIL random nb=%0d dec=%b: outp=%h expected %h", nb, d, outp_m, exp_v);
            end
            finish_xact("random");
        end
        sel = 1'b0;
    endtask

    task automatic test_back_pressure();
        logic [31:0][7:0] din, din2, held;
        logic d2;
        int lat;
        sel = 1'b0;
        din = rand_state();
        start_xact(din, 1'b1, "bp_first");
        held = outp_m;
        for (int i = 0; i < 10; i++) begin
            in_valid  = 1'b1;
            inp       = rand_state();
            out_ready = 1'b0;
            tick();
            checks++;
            if (outp_m !== held || in_ready_m !== 1'b0 || out_valid_m !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold cycle %0d: outp=%h in_ready=%b out_valid=%b expected %h/0/1",
                         i, outp_m, in_ready_m, out_valid_m, held);
            end
        end
        din2 = rand_state();
        d2   = 1'($urandom);
        inp  = din2;
        dec  = d2;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready_m !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: in_ready=%b expected 1", in_ready_m);
        end
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        inp       = rand_state();
        dec       = ~d2;
        checks++;
        if (done_m !== 1'b1) begin
            failures++;
            $display("FAIL bp_done: done=%b expected 1", done_m);
        end
        lat = 0;
        while (out_valid_m !== 1'b1 && lat < 20) begin
            lat++;
            tick();
        end
        checks++;
        if (lat != 4 || outp_m !== model(4, d2, din2)) begin
            failures++;
            $display("FAIL bp_next: edges=%0d outp=%h expected 4/%h", lat, outp_m, model(4, d2, din2));
        end
        finish_xact("bp_next");
    endtask

    task automatic test_back_to_back();
        logic [31:0][7:0] q[$];
        int last, seen;
        sel = 1'b0; last = -1; seen = 0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        inp = rand_state();
        dec = 1'($urandom);
        for (int cyc = 0; cyc < 30; cyc++) begin
            #1;
            if (out_valid_m === 1'b1) begin
                checks++;
                if (q.size() == 0 || outp_m !== q[0]) begin
                    failures++;
                    $display("FAIL b2b_data cycle %0d: outp=%h", cyc, outp_m);
                end
                if (q.size() != 0) void'(q.pop_front());
                if (last >= 0) begin
                    checks++;
                    if (cyc - last != 5) begin
                        failures++;
                        $display("FAIL b2b_rate: spacing=%0d expected 5", cyc - last);
                    end
                end
                last = cyc;
                seen++;
            end
            if (in_ready_m === 1'b1) q.push_back(model(4, dec, inp));
            tick();
            inp = rand_state();
            dec = 1'($urandom);
        end
        checks++;
        if (seen < 5) begin
            failures++;
            $display("FAIL b2b_count: results=%0d expected at least 5", seen);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_row();
        int bad;
        sel = 1'b0;
        in_valid = 1'b1;
        inp = rand_state();
        dec = 1'b0;
        tick();                 // accepting edge
        in_valid = 1'b0;
        tick();                 // now in ROW cycle 2
        resetn = 1'b1;
        tick();
        resetn = 1'b0;
        #1;
        checks++;
        if (outp_m !== '0 || out_valid_m !== 1'b0 || in_ready_m !== 1'b1 || done_m !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_row: outp=%h out_valid=%b in_ready=%b done=%b expected 0/0/1/0",
                     outp_m, out_valid_m, in_ready_m, done_m);
        end
        out_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid_m !== 1'b0 || done_m !== 1'b0) bad++;
        end
        out_ready = 1'b0;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL reset_abort: %0d cycles with out_valid/done, expected 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_nb8_wrap();
        test_random();
        test_back_pressure();
        test_back_to_back();
        test_reset_mid_row();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
